// File: rtl/floppy_pkg.sv
// Shared definitions for the floppy sector path: default sizes and the
// sector-buffer write FSM state type.
package floppy_pkg;
    localparam int SECTOR_BYTES_DEFAULT = 512;
    localparam int CNT_W_DEFAULT        = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DISCARD = 2'd2
    } wr_state_e;
endpackage

// File: rtl/sector_buffer_if.sv
// Byte-stream input, reader port and statistics of the sector buffer.
// The master drives the stream and reader inputs; the slave is the buffer.
interface sector_buffer_if import floppy_pkg::*; #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = CNT_W_DEFAULT
);
    logic [7:0]        i_Data;
    logic              i_Valid;
    logic [7:0]        i_Sector;
    logic              i_HeaderCRCError;
    logic              i_DataCRCError;
    logic              i_Done;
    logic [ADDR_W-1:0] i_RdAddr;
    logic [7:0]        o_RdData;
    logic              o_Avail;
    logic [7:0]        o_AvailSector;
    logic              i_Release;
    logic [CNT_W-1:0]  o_GoodCount;
    logic [CNT_W-1:0]  o_BadCount;
    logic [CNT_W-1:0]  o_DropCount;

    modport master (
        output i_Data, i_Valid, i_Sector, i_HeaderCRCError, i_DataCRCError,
               i_Done, i_RdAddr, i_Release,
        input  o_RdData, o_Avail, o_AvailSector, o_GoodCount, o_BadCount,
               o_DropCount
    );

    modport slave (
        input  i_Data, i_Valid, i_Sector, i_HeaderCRCError, i_DataCRCError,
               i_Done, i_RdAddr, i_Release,
        output o_RdData, o_Avail, o_AvailSector, o_GoodCount, o_BadCount,
               o_DropCount
    );
endinterface

// File: rtl/sector_buffer_ram.sv
// Simple dual-port byte RAM, one write port and one registered read port.
// The array carries no reset so it maps onto block RAM.
module sector_buffer_ram #(
    parameter int AW = 10
) (
    input  logic          i_Clk,
    input  logic          i_We,
    input  logic [AW-1:0] i_WAddr,
    input  logic [7:0]    i_WData,
    input  logic [AW-1:0] i_RAddr,
    output logic [7:0]    o_RData
);
    logic [7:0] mem [2**AW];
    logic [7:0] rd_data_q;

    always_ff @(posedge i_Clk) begin
        if (i_We) begin
            mem[i_WAddr] <= i_WData;
        end
        rd_data_q <= mem[i_RAddr];
    end

    assign o_RData = rd_data_q;
endmodule

// File: rtl/sector_buffer.sv
// Ping-pong sector store: commits complete, CRC-clean sectors into one of two
// banks and hands committed banks to a reader in commit order.
module sector_buffer import floppy_pkg::*; #(
    parameter int SECTOR_BYTES = SECTOR_BYTES_DEFAULT,
    parameter int ADDR_W       = 9,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic            i_Clk,
    input  logic            i_Reset_n,
    sector_buffer_if.slave  bus
);
    localparam int BC_W = ADDR_W + 2;
    localparam logic [BC_W-1:0] SECTOR_LEN = BC_W'(SECTOR_BYTES);

    wr_state_e         state_q, state_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]        sector_q, sector_d;
    logic              hdr_err_q, hdr_err_d;
    logic              len_err_q, len_err_d;
    logic              blocked_q, blocked_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic [1:0][7:0]   bank_sector_q, bank_sector_d;
    logic [CNT_W-1:0]  good_q, good_d, bad_q, bad_d, drop_q, drop_d;
    logic              rd_valid_q;
    logic              sector_good;
    logic              ram_we;
    logic [ADDR_W:0]   ram_waddr;
    logic [7:0]        ram_rdata;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q       <= IDLE;
            byte_cnt_q    <= '0;
            sector_q      <= '0;
            hdr_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            blocked_q     <= 1'b0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            bank_full_q   <= '0;
            bank_sector_q <= '0;
            good_q        <= '0;
            bad_q         <= '0;
            drop_q        <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            sector_q      <= sector_d;
            hdr_err_q     <= hdr_err_d;
            len_err_q     <= len_err_d;
            blocked_q     <= blocked_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            bank_full_q   <= bank_full_d;
            bank_sector_q <= bank_sector_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
            drop_q        <= drop_d;
            rd_valid_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        sector_d      = sector_q;
        hdr_err_d     = hdr_err_q;
        len_err_d     = len_err_q;
        blocked_d     = blocked_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        bank_full_d   = bank_full_q;
        bank_sector_d = bank_sector_q;
        good_d        = good_q;
        bad_d         = bad_q;
        drop_d        = drop_q;
        ram_we        = 1'b0;
        ram_waddr     = {wr_bank_q, byte_cnt_q[ADDR_W-1:0]};
        sector_good   = !hdr_err_q && !bus.i_DataCRCError && !len_err_q &&
                        (byte_cnt_q == SECTOR_LEN);

        // A commit never targets the bank being released: commit needs an
        // empty write bank, release needs a full read bank.
        if (bus.i_Release && bank_full_q[rd_bank_q]) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.i_Valid) begin
                    sector_d   = bus.i_Sector;
                    hdr_err_d  = bus.i_HeaderCRCError;
                    len_err_d  = 1'b0;
                    blocked_d  = bank_full_q[wr_bank_q];
                    byte_cnt_d = BC_W'(1);
                    ram_we     = !bank_full_q[wr_bank_q];
                    ram_waddr  = {wr_bank_q, {ADDR_W{1'b0}}};
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (bus.i_Done) begin
                    if (!sector_good) begin
                        if (bad_q != '1) bad_d = bad_q + 1'b1;
                    end else if (blocked_q) begin
                        if (drop_q != '1) drop_d = drop_q + 1'b1;
                    end else begin
                        bank_full_d[wr_bank_q]   = 1'b1;
                        bank_sector_d[wr_bank_q] = sector_q;
                        wr_bank_d                = ~wr_bank_q;
                        if (good_q != '1) good_d = good_q + 1'b1;
                    end
                    state_d = IDLE;
                end else if (bus.i_Valid) begin
                    if (byte_cnt_q == '1) begin
                        len_err_d = 1'b1;
                        state_d   = DISCARD;
                    end else begin
                        if (byte_cnt_q < SECTOR_LEN) begin
                            ram_we = !blocked_q;
                        end else begin
                            len_err_d = 1'b1;
                        end
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (bus.i_Done) begin
                    if (bad_q != '1) bad_d = bad_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sector_buffer_ram #(.AW(ADDR_W + 1)) u_ram (
        .i_Clk   (i_Clk),
        .i_We    (ram_we),
        .i_WAddr (ram_waddr),
        .i_WData (bus.i_Data),
        .i_RAddr ({rd_bank_q, bus.i_RdAddr}),
        .o_RData (ram_rdata)
    );

    // The RAM read register has no reset; gate it so reset shows zero.
    assign bus.o_RdData      = rd_valid_q ? ram_rdata : 8'h00;
    assign bus.o_Avail       = bank_full_q[rd_bank_q];
    assign bus.o_AvailSector = bank_sector_q[rd_bank_q];
    assign bus.o_GoodCount   = good_q;
    assign bus.o_BadCount    = bad_q;
    assign bus.o_DropCount   = drop_q;
endmodule
